// File: rtl/dmem_pkg.sv
// Shared types and RV32I load/store width codes for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 word storage: combinational read, byte-enabled synchronous write.
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Write only the enabled byte lanes; other lanes keep their contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed access latency.
// A request is captured in IDLE, the access happens when the BUSY countdown
// reaches zero, and the response is held in RESP until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_done;
  logic        w_err;
  logic        w_oor;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_ram_we;
  logic [3:0]  w_ram_be;
  logic [31:0] w_ram_wdata;
  logic [31:0] w_ram_rdata;
  logic [29:0] w_idx;

  // Select the addressed byte/halfword/word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                           input logic [31:0] word,
                                           input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      LB:      load_ext = {{24{sh[7]}}, sh[7:0]};
      LBU:     load_ext = {24'h0, sh[7:0]};
      LH:      load_ext = {{16{sh[15]}}, sh[15:0]};
      LHU:     load_ext = {16'h0, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  // Byte-lane enables for a store of the given width at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      SB:      store_be = 4'b0001 << off;
      SH:      store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the byte enable picks the right copy.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      SB:      store_data = {4{wd[7:0]}};
      SH:      store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_done     = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_idx      = r_addr[31:2];
  assign w_oor      = (w_idx >= DEPTH_W);
  assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                      ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_illegal  = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) ||
                      (r_funct3 == 3'b111) || (r_we && r_funct3[2]);
  assign w_err       = w_oor || w_misalign || w_illegal;
  assign w_ram_be    = store_be(r_funct3, r_addr[1:0]);
  assign w_ram_wdata = store_data(r_funct3, r_wdata);

  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // State register and latency countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)                                r_cnt <= LAT_M1;
      else if (r_state == ST_BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid)      w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0)  w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)      w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs and the write strobe; reset blocks a pending store.
  always_comb begin
    req_ready = (r_state == ST_IDLE);
    rsp_valid = (r_state == ST_RESP);
    w_ram_we  = w_done && r_we && !w_err && !rst;
  end

  // Request capture at acceptance and response registers at BUSY exit.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr;
      r_funct3 <= req_funct3;
      r_wdata  <= req_wdata;
    end
    if (rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_done) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_we) ? 32'h0 : load_ext(r_funct3, w_ram_rdata, r_addr[1:0]);
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected
// responses; a negedge monitor checks every presented response.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          seen;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: compare every presented response against the head of the queue.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        if (!sb_q[0].seen) begin
          chk({sb_q[0].nm, "_latency"}, 32'(cyc - sb_q[0].acc), 32'(LAT));
          sb_q[0].seen = 1'b1;
        end
        chk({sb_q[0].nm, "_rdata"}, rsp_rdata, sb_q[0].rdata);
        chk({sb_q[0].nm, "_err"}, 32'(rsp_err), 32'(sb_q[0].err));
        chk({sb_q[0].nm, "_req_ready"}, 32'(req_ready), 32'd0);
        if (rsp_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk({nm, "_rsp_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Present one request, hold it through the accepting edge, queue its expectation.
  task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input string nm, input bit exp_rsp);
    exp_t e;
    wait_ready(nm);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_rsp) begin
      e.rdata = er; e.err = ee; e.acc = cyc; e.seen = 1'b0; e.nm = nm;
      sb_q.push_back(e);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee,
                      input string nm);
    issue(we, a, f3, wd, er, ee, nm, 1'b1);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_funct3 = 3'b0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err",   32'(rsp_err), 32'd0);
    rst = 1'b0;

    // Word store then load back.
    xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    xfer(1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    // Sub-word loads with sign / zero extension.
    xfer(1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_13");
    xfer(1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0, "lbu_13");
    xfer(1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0, "lh_12");
    xfer(1'b0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10");
    // Partial stores merge into the word.
    xfer(1'b1, 32'h11, 3'b000, 32'h00000055, 32'h0, 1'b0, "sb_11");
    xfer(1'b1, 32'h12, 3'b001, 32'h00001234, 32'h0, 1'b0, "sh_12");
    xfer(1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, "lw_merged");
    xfer(1'b0, 32'h11, 3'b000, 32'h0, 32'h00000055, 1'b0, "lb_11_pos");
    // Error cases: misaligned, illegal funct3, out of range; no write on error.
    xfer(1'b0, 32'h11, 3'b010, 32'h0, 32'h0, 1'b1, "lw_misal");
    xfer(1'b1, 32'h13, 3'b001, 32'h0000FFFF, 32'h0, 1'b1, "sh_misal");
    xfer(1'b1, 32'h10, 3'b100, 32'h000000AA, 32'h0, 1'b1, "st_illegal");
    xfer(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, "ld_illegal");
    xfer(1'b0, 32'(DEPTH * 4), 3'b010, 32'h0, 32'h0, 1'b1, "lw_oor");
    xfer(1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, "lw_after_err");

    // Response back-pressure; a store offered meanwhile must be ignored.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, "lw_hold", 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
      req_funct3 = 3'b010; req_wdata = 32'h0;
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done("lw_hold");
    xfer(1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0, "lw_after_hold");

    // Reset on the commit edge of a store drops it.
    xfer(1'b1, 32'h20, 3'b010, 32'h01020304, 32'h0, 1'b0, "sw_20_pre");
    issue(1'b1, 32'h20, 3'b010, 32'hA5A5A5A5, 32'h0, 1'b0, "sw_20_rst", 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    xfer(1'b0, 32'h20, 3'b010, 32'h0, 32'h01020304, 1'b0, "lw_20_after_rst");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit memory words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning clock edges from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the requester presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_funct3, input, 3 bits: RV32I load/store width code.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the requester accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load result, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: access fault.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESP; one transaction outstanding at most.
REQ-016 SHALL drive req_ready=1 only in IDLE; an edge with req_valid&req_ready SHALL capture all req_* fields, load the counter with LATENCY-1 and enter BUSY.
REQ-017 In BUSY, each edge SHALL decrement the counter; at the edge where the counter is 0, the FSM SHALL perform the access, register rsp_rdata/rsp_err and enter RESP. rsp_valid therefore rises exactly LATENCY edges after the accepting edge.
REQ-018 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL stay stable until an edge with rsp_ready=1, which returns the FSM to IDLE. Back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-019 Loads: funct3 000 LB and 100 LBU SHALL select byte addr[1:0]; 001 LH and 101 LHU SHALL select halfword addr[1]; 010 LW selects the full word. LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
REQ-020 Stores: 000 SB SHALL write one byte lane at addr[1:0] using wdata[7:0]; 001 SH SHALL write two lanes at addr[1] using wdata[15:0]; 010 SW SHALL write all four lanes. Untouched lanes SHALL keep their contents.
REQ-021 Word index SHALL be addr[31:2]. An index >= DEPTH SHALL be out of range.
REQ-022 rsp_err=1 SHALL result from any of: misalignment (half with addr[0]=1, word with addr[1:0]!=0), out of range, an illegal funct3 (011/110/111 for any access, or 1xx for a store). On error, no write SHALL occur and rsp_rdata SHALL be 0.
REQ-023 A store SHALL commit at the edge where BUSY exits, not at acceptance. A load issued after a store's response SHALL observe the stored data.
REQ-024 Request inputs SHALL be ignored while not in IDLE.

Reset
REQ-025 While rst=1 at an edge, the FSM SHALL go to IDLE, the counter to 0, rsp_valid to 0, rsp_rdata to 0 and rsp_err to 0; req_ready SHALL be 1 after the first reset edge.
REQ-026 Reset in BUSY or RESP SHALL drop the transaction without a response. A pending store SHALL NOT be committed. Memory contents SHALL NOT be cleared by reset.

Structure
REQ-027 Package dmem_pkg SHALL hold the state enum and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-028 The storage SHALL be a sub-module dmem_ram: DEPTH x 32, combinational read, synchronous write with a 4-bit byte enable.

Verification
REQ-029 Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid rises exactly 2 edges after each accept; rdata 0xDEADBEEF; err 0.
REQ-030 After REQ-029: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-031 After REQ-029: SB 0x11 data 0x55 and SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
REQ-032 LW 0x11, SH 0x13 and LW at byte address DEPTH*4 -> err=1, rdata 0; a following LW of the affected word shows unchanged data.
REQ-033 Hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stay stable, and req_ready stays 0; a new req_valid during that time is ignored.
REQ-034 Assert rst in the BUSY cycle of SW 0x20 data 0xA5A5A5A5 -> no response; a subsequent LW 0x20 returns the pre-store value.
